// File: rtl/trig_capture_pkg.sv
// Shared definitions for the triggered capture counter: FSM encoding and
// the BRAM byte-address width.
package trig_capture_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PENDING = 2'd2,
    ST_WRITE   = 2'd3
  } state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// Registers the trigger every clock and flags a 0->1 transition in the
// same cycle the input rises.
module rising_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic in,
  output logic edge_det
);

  logic trig_q;

  // Delay the input by one clock; not gated by any enable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) trig_q <= 1'b0;
    else         trig_q <= in;
  end

  assign edge_det = in & ~trig_q;

endmodule

// File: rtl/trig_capture_counter.sv
// Triggered frame capture: a free-running word counter drives a BRAM
// address; after arm and a trigger edge, one full frame (addresses
// 0..count_max) is written with wen, then the block re-arms or idles.
module trig_capture_counter
  import trig_capture_pkg::*;
#(
  parameter int COUNT_WIDTH     = 13,
  parameter int ADDR_LSB        = 2,
  parameter int WEN_WIDTH       = 4,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clken,
  input  logic                       trig,
  input  logic                       arm,
  input  logic                       continuous,
  input  logic                       abort,
  output logic [ADDR_W-1:0]          address,
  output logic [WEN_WIDTH-1:0]       wen,
  output logic                       busy,
  output logic                       done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  if (COUNT_WIDTH + ADDR_LSB > ADDR_W) begin : g_width_err
    $error("trig_capture_counter: COUNT_WIDTH + ADDR_LSB exceeds the 32-bit address");
  end

  logic [COUNT_WIDTH-1:0] count;
  logic                   at_max;
  logic                   trig_edge;
  logic                   frame_end;
  logic                   write_on;
  state_t                 state;
  state_t                 state_nxt;

  rising_edge_detect u_edge (
    .clk      (clk),
    .resetn   (resetn),
    .in       (trig),
    .edge_det (trig_edge)
  );

  // Free-running word counter, wraps naturally at count_max.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    count <= '0;
    else if (clken) count <= count + COUNT_WIDTH'(1);
  end

  assign at_max  = (count == {COUNT_WIDTH{1'b1}});
  assign address = ADDR_W'(count) << ADDR_LSB;

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // FSM next state; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:    if (arm)              state_nxt = ST_ARMED;
        ST_ARMED:   if (trig_edge)        state_nxt = ST_PENDING;
        // Wait for the wrap so the first write lands on address 0.
        ST_PENDING: if (clken && at_max)  state_nxt = ST_WRITE;
        ST_WRITE:   if (clken && at_max)  state_nxt = continuous ? ST_ARMED : ST_IDLE;
        default:                          state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    write_on  = (state == ST_WRITE);
    busy      = (state != ST_IDLE);
    frame_end = write_on && clken && at_max && !abort;
  end

  assign wen = {WEN_WIDTH{write_on}};

  // Completion pulse and saturating frame counter; arming clears the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      done <= frame_end;
      if (state == ST_IDLE && arm && !abort)
        frame_count <= '0;
      else if (frame_end && frame_count != {FRAME_CNT_WIDTH{1'b1}})
        frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/trig_capture_counter.md
TRIG_CAPTURE_COUNTER -- requirements
Module: trig_capture_counter

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 13, frame depth is 2^COUNT_WIDTH words.
REQ-002 SHALL have parameter ADDR_LSB, default 2, byte-address shift applied to the count.
REQ-003 SHALL have parameter WEN_WIDTH, default 4, write-enable replication width.
REQ-004 SHALL have parameter FRAME_CNT_WIDTH, default 16, completed-frame counter width.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 clken  in  1  count/sample enable.
REQ-008 trig  in  1  trigger, may be asynchronous to the frame.
REQ-009 arm  in  1  level, arms capture when in IDLE.
REQ-010 continuous  in  1  1 = re-arm automatically after each frame.
REQ-011 abort  in  1  forces return to IDLE.
REQ-012 address  out  32  BRAM byte address.
REQ-013 wen  out  WEN_WIDTH  BRAM write enable, all bits equal.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse on frame completion.
REQ-016 frame_count  out  FRAME_CNT_WIDTH  number of completed frames.

Function
REQ-017 Count SHALL increment by 1 on each clk with clken=1, free-running, and wrap from count_max = 2^COUNT_WIDTH-1 to 0.
REQ-018 address SHALL equal count shifted left by ADDR_LSB, zero-extended to 32 bits (combinational from count).
REQ-019 trig SHALL be registered every clk regardless of clken; edge = trig & ~trig_q.
REQ-020 FSM states SHALL be IDLE, ARMED, PENDING, WRITE.
REQ-021 IDLE: arm=1 -> ARMED, and frame_count cleared to 0 in the same cycle.
REQ-022 ARMED: edge=1 -> PENDING; an edge coincident with the IDLE->ARMED transition is ignored.
REQ-023 PENDING: clken=1 and count==count_max -> WRITE, so the first write is at count 0.
REQ-024 WRITE: clken=1 and count==count_max ends the frame: -> ARMED if continuous=1, else -> IDLE.
REQ-025 On frame end, done SHALL pulse high for exactly the next cycle, and frame_count SHALL increment, saturating at all-ones.
REQ-026 wen SHALL be high iff state==WRITE, so each frame writes exactly 2^COUNT_WIDTH clken-qualified addresses 0..count_max.
REQ-027 clken=0 during WRITE SHALL hold count and wen; the same address is rewritten, which is accepted.
REQ-028 Edges in PENDING or WRITE SHALL be ignored, with no queuing.
REQ-029 abort=1 SHALL force IDLE on the next clk from any state, dropping wen, with no done pulse and no frame_count change; abort has priority over all other transitions.
REQ-030 continuous changing mid-frame SHALL take effect at frame end only (sampled at the end cycle).
REQ-031 COUNT_WIDTH+ADDR_LSB > 32 SHALL be a elaboration error.

Reset
REQ-032 resetn=0 SHALL asynchronously set state=IDLE, count=0, trig_q=0, wen=0, busy=0, done=0, frame_count=0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no done pulse; after release the block waits for arm.

Structure
REQ-034 FSM state encoding and the address-width localparam SHALL live in shared package trig_capture_pkg.
REQ-035 Edge detection SHALL be a sub-module rising_edge_detect (clk, resetn, in, edge).

Verification (COUNT_WIDTH=4, ADDR_LSB=2, WEN_WIDTH=4, clken=1 unless stated)
REQ-036 Sequence arm, then trig edge at count 5 -> WRITE entered at count 0; wen=4'hF for 16 cycles over address 0x00..0x3C; done pulses once; frame_count=1; busy=0.
REQ-037 continuous=1, trig edges before each frame end -> back-to-back frames with one PENDING gap each; frame_count=3 after three frames.
REQ-038 clken toggled 1-0-1 during WRITE -> wen held; address advances only on clken=1; still 16 distinct addresses written.
REQ-039 abort asserted at count 7 of WRITE -> wen=0 next cycle; state IDLE; no done pulse; frame_count unchanged.
REQ-040 Edges in IDLE, edge coincident with arm, and edges during WRITE -> no effect; only an edge seen in ARMED starts a frame.
REQ-041 resetn pulsed low mid-frame, asynchronous to clk -> all outputs 0 immediately; no done pulse; a new arm plus trig works normally.
